// File: rtl/fault_pos_tracker.sv
// Per-router tracker of power-gated mesh nodes: debounces each pg_en/pg_node channel,
// then registers a relative-position code per channel and pulses pos_update on any change.
module fault_pos_tracker #(
  parameter int LOCAL_X    = 0,
  parameter int LOCAL_Y    = 0,
  parameter int COORD_W    = 3,
  parameter int MESH_X     = 8,
  parameter int MESH_Y     = 8,
  parameter int NUM_FAULTS = 2,
  parameter int STABLE_CYC = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_FAULTS-1:0]             pg_en,
  input  logic [NUM_FAULTS*2*COORD_W-1:0]   pg_node,
  output logic [NUM_FAULTS*4-1:0]           fault_relative_pos,
  output logic [NUM_FAULTS-1:0]             fault_valid,
  output logic [NUM_FAULTS-1:0]             self_gated,
  output logic                              any_fault,
  output logic                              pos_update,
  output logic                              cfg_err
);

  localparam int CW = 2 * COORD_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;

  localparam logic [3:0] POS_NORMAL = 4'd0;
  localparam logic [3:0] POS_N      = 4'd1;
  localparam logic [3:0] POS_S      = 4'd2;
  localparam logic [3:0] POS_E      = 4'd3;
  localparam logic [3:0] POS_W      = 4'd4;
  localparam logic [3:0] POS_NE     = 4'd5;
  localparam logic [3:0] POS_NW     = 4'd6;
  localparam logic [3:0] POS_SE     = 4'd7;
  localparam logic [3:0] POS_SW     = 4'd8;

  localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);
  localparam logic [31:0]        MX = 32'(MESH_X);
  localparam logic [31:0]        MY = 32'(MESH_Y);
  localparam logic [3:0]         STABLE_M1 = 4'(STABLE_CYC - 1);

  logic [NUM_FAULTS-1:0][1:0]    state_q, state_d;
  logic [NUM_FAULTS-1:0][CW-1:0] cand_q,  cand_d;
  logic [NUM_FAULTS-1:0][3:0]    cnt_q,   cnt_d;
  logic [NUM_FAULTS-1:0][3:0]    pos_q,   pos_d;
  logic [NUM_FAULTS-1:0]         valid_q, valid_d;
  logic [NUM_FAULTS-1:0]         self_q,  self_d;
  logic                          any_q,   any_d;
  logic                          upd_q,   upd_d;
  logic                          err_q,   err_d;

  function automatic logic in_range(input logic [CW-1:0] n);
    return (32'(n[COORD_W-1:0]) < MX) && (32'(n[CW-1:COORD_W]) < MY);
  endfunction

  function automatic logic is_self(input logic [CW-1:0] n);
    return n == {LY, LX};
  endfunction

  function automatic logic [3:0] relpos(input logic [CW-1:0] n);
    logic [COORD_W-1:0] fx, fy;
    fx = n[COORD_W-1:0];
    fy = n[CW-1:COORD_W];
    if (fx == LX && fy == LY) return POS_NORMAL;
    if (LY > fy) return (LX < fx) ? POS_NW : (LX == fx) ? POS_N : POS_NE;
    if (LY == fy) return (LX < fx) ? POS_W : POS_E;
    return (LX < fx) ? POS_SW : (LX == fx) ? POS_S : POS_SE;
  endfunction

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    valid_d = valid_q;
    self_d  = self_q;
    err_d   = err_q;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      logic [CW-1:0] node;
      node = pg_node[i*CW +: CW];
      case (state_q[i])
        S_IDLE: begin
          if (pg_en[i]) begin
            if (!in_range(node)) begin
              err_d = 1'b1;
            end else begin
              cand_d[i] = node;
              cnt_d[i]  = 4'd1;
              if (STABLE_CYC == 1) begin
                state_d[i] = S_ACT;
                valid_d[i] = 1'b1;
                pos_d[i]   = relpos(node);
                self_d[i]  = is_self(node);
              end else begin
                state_d[i] = S_PEND;
              end
            end
          end
        end
        S_PEND: begin
          if (!pg_en[i] || (node != cand_q[i] && !in_range(node))) begin
            // Dropping out of PEND releases whatever was committed before the move
            err_d      = err_q | pg_en[i];
            state_d[i] = S_IDLE;
            valid_d[i] = 1'b0;
            pos_d[i]   = POS_NORMAL;
            self_d[i]  = 1'b0;
          end else if (node != cand_q[i]) begin
            cand_d[i] = node;
            cnt_d[i]  = 4'd1;
          end else if (cnt_q[i] == STABLE_M1) begin
            state_d[i] = S_ACT;
            valid_d[i] = 1'b1;
            pos_d[i]   = relpos(cand_q[i]);
            self_d[i]  = is_self(cand_q[i]);
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end
        S_ACT: begin
          if (!pg_en[i]) begin
            state_d[i] = S_IDLE;
            valid_d[i] = 1'b0;
            pos_d[i]   = POS_NORMAL;
            self_d[i]  = 1'b0;
          end else if (node != cand_q[i]) begin
            if (!in_range(node)) begin
              err_d = 1'b1;
            end else begin
              cand_d[i] = node;
              cnt_d[i]  = 4'd1;
              if (STABLE_CYC == 1) begin
                pos_d[i]  = relpos(node);
                self_d[i] = is_self(node);
              end else begin
                state_d[i] = S_PEND;
              end
            end
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
    any_d = |(valid_d & ~self_d);
    upd_d = ({valid_d, pos_d} != {valid_q, pos_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      valid_q <= '0;
      self_q  <= '0;
      any_q   <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      self_q  <= self_d;
      any_q   <= any_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign fault_relative_pos = pos_q;
  assign fault_valid        = valid_q;
  assign self_gated         = self_q;
  assign any_fault          = any_q;
  assign pos_update         = upd_q;
  assign cfg_err            = err_q;

endmodule

// File: tb/tb_fault_pos_tracker.sv
// Directed bench for fault_pos_tracker (LOCAL=(3,3), COORD_W=4, 8x8 mesh, 2 channels).
module tb_fault_pos_tracker;

  localparam logic [3:0] P_NORMAL = 4'd0;
  localparam logic [3:0] P_N      = 4'd1;
  localparam logic [3:0] P_W      = 4'd4;
  localparam logic [3:0] P_SE     = 4'd7;
  localparam logic [3:0] P_SW     = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pg_en = '0;
  logic [15:0] pg_node = '0;
  logic [7:0]  fault_relative_pos;
  logic [1:0]  fault_valid;
  logic [1:0]  self_gated;
  logic        any_fault;
  logic        pos_update;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] pos;
    logic [1:0] vld;
    logic [1:0] slf;
    logic       any;
    logic       upd;
    logic       cfg;
  } exp_t;

  exp_t sb[$];

  fault_pos_tracker #(
    .LOCAL_X(3), .LOCAL_Y(3), .COORD_W(4), .MESH_X(8), .MESH_Y(8),
    .NUM_FAULTS(2), .STABLE_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pg_en(pg_en), .pg_node(pg_node),
    .fault_relative_pos(fault_relative_pos), .fault_valid(fault_valid),
    .self_gated(self_gated), .any_fault(any_fault), .pos_update(pos_update),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] nd(input int x, input int y);
    return {4'(y), 4'(x)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input exp_t e);
    check({e.tag, ".pos"}, fault_relative_pos, e.pos);
    check({e.tag, ".valid"}, {6'd0, fault_valid}, {6'd0, e.vld});
    check({e.tag, ".self"}, {6'd0, self_gated}, {6'd0, e.slf});
    check({e.tag, ".any"}, {7'd0, any_fault}, {7'd0, e.any});
    check({e.tag, ".upd"}, {7'd0, pos_update}, {7'd0, e.upd});
    check({e.tag, ".cfg"}, {7'd0, cfg_err}, {7'd0, e.cfg});
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, then pop and compare.
  task automatic cyc(input string tag, input logic [1:0] en, input logic [7:0] n0,
                     input logic [7:0] n1, input logic [7:0] pos, input logic [1:0] vld,
                     input logic [1:0] slf, input logic any, input logic upd, input logic cfg);
    exp_t e;
    pg_en   = en;
    pg_node = {n1, n0};
    e.tag = tag; e.pos = pos; e.vld = vld; e.slf = slf; e.any = any; e.upd = upd; e.cfg = cfg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      compare_all(sb.pop_front());
    end
  endtask

  initial begin
    exp_t r;
    r.tag = "reset"; r.pos = 8'h00; r.vld = 2'b00; r.slf = 2'b00; r.any = 0; r.upd = 0; r.cfg = 0;
    #12;
    compare_all(r);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ch0 (5,3) west of local, commits on the 4th sampling edge
    for (int k = 1; k <= 3; k++) cyc("w_wait", 2'b01, nd(5,3), 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 0);
    cyc("w_commit", 2'b01, nd(5,3), 8'h00, {P_NORMAL, P_W}, 2'b01, 2'b00, 1, 1, 0);
    cyc("w_hold",   2'b01, nd(5,3), 8'h00, {P_NORMAL, P_W}, 2'b01, 2'b00, 1, 0, 0);

    // ch1 (3,1) north, ch0 unchanged
    for (int k = 1; k <= 3; k++) cyc("n_wait", 2'b11, nd(5,3), nd(3,1), {P_NORMAL, P_W}, 2'b01, 2'b00, 1, 0, 0);
    cyc("n_commit", 2'b11, nd(5,3), nd(3,1), {P_N, P_W}, 2'b11, 2'b00, 1, 1, 0);
    cyc("n_hold",   2'b11, nd(5,3), nd(3,1), {P_N, P_W}, 2'b11, 2'b00, 1, 0, 0);

    // ch0 release is immediate
    cyc("rel0",      2'b10, nd(5,3), nd(3,1), {P_N, P_NORMAL}, 2'b10, 2'b00, 1, 1, 0);
    cyc("rel0_hold", 2'b10, nd(5,3), nd(3,1), {P_N, P_NORMAL}, 2'b10, 2'b00, 1, 0, 0);

    // ch1 moves onto the local node: old outputs hold, then self-gated commit
    for (int k = 1; k <= 3; k++) cyc("self_wait", 2'b10, 8'h00, nd(3,3), {P_N, P_NORMAL}, 2'b10, 2'b00, 1, 0, 0);
    cyc("self_commit", 2'b10, 8'h00, nd(3,3), 8'h00, 2'b10, 2'b10, 0, 1, 0);
    cyc("self_hold",   2'b10, 8'h00, nd(3,3), 8'h00, 2'b10, 2'b10, 0, 0, 0);
    cyc("self_rel",    2'b00, 8'h00, nd(3,3), 8'h00, 2'b00, 2'b00, 0, 1, 0);

    // ch0 node toggles at edge 2: counter restarts, commit at edge 5
    cyc("tog_1", 2'b01, nd(5,3), 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 0);
    for (int k = 2; k <= 4; k++) cyc("tog_wait", 2'b01, nd(5,4), 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 0);
    cyc("tog_commit", 2'b01, nd(5,4), 8'h00, {P_NORMAL, P_SW}, 2'b01, 2'b00, 1, 1, 0);
    cyc("tog_hold",   2'b01, nd(5,4), 8'h00, {P_NORMAL, P_SW}, 2'b01, 2'b00, 1, 0, 0);

    // move to (6,4): same code recommitted, no pulse
    for (int k = 1; k <= 5; k++) cyc("same_code", 2'b01, nd(6,4), 8'h00, {P_NORMAL, P_SW}, 2'b01, 2'b00, 1, 0, 0);

    // ch1 (1,5) south-east, then both released together: one pulse
    for (int k = 1; k <= 3; k++) cyc("se_wait", 2'b11, nd(6,4), nd(1,5), {P_NORMAL, P_SW}, 2'b01, 2'b00, 1, 0, 0);
    cyc("se_commit", 2'b11, nd(6,4), nd(1,5), {P_SE, P_SW}, 2'b11, 2'b00, 1, 1, 0);
    cyc("both_rel",  2'b00, nd(6,4), nd(1,5), 8'h00, 2'b00, 2'b00, 0, 1, 0);
    cyc("both_idle", 2'b00, nd(6,4), nd(1,5), 8'h00, 2'b00, 2'b00, 0, 0, 0);

    // out-of-range x=9: sticky error, channel stays idle
    cyc("oor",        2'b01, nd(9,0), 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 1);
    for (int k = 1; k <= 4; k++) cyc("oor_idle", 2'b01, nd(9,0), 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 1);
    cyc("oor_sticky", 2'b00, nd(9,0), 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 1);

    // reset during PEND with cnt=2 drops the candidate
    cyc("pre_rst_1", 2'b01, nd(5,3), 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 1);
    cyc("pre_rst_2", 2'b01, nd(5,3), 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 1);
    rst_n = 1'b0;
    #2;
    r.tag = "mid_reset";
    compare_all(r);
    pg_en = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) cyc("post_rst", 2'b00, nd(5,3), 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 0);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
